cart_bank_mapper: RTL and testbench

- Generalised successor to the fixed-type cartridge mapper.
- Parametrised bank-table cartridge mapper with a table built from CRT chip packets while loading.
- Provides register-driven ROML/ROMH bank switching with power-of-two mirroring, EXROM/GAME control, an optional IOF RAM page, and a freeze/NMI handshake FSM with timeout.
- Sits between the C64 bus decode and the SDRAM address path.

---
 rtl/cart_bank_mapper.sv | 217 +++++++++++++++++++++
 tb/tb_cart_bank_mapper.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cart_bank_mapper.sv
// cart_bank_mapper
//   Bank-table cartridge mapper. A page table is filled from CRT chip
//   packets while the file loads; at run time ROML/ROMH reads are translated
//   through the currently selected bank, with power-of-two mirroring derived
//   from the highest bank seen. Also drives EXROM/GAME, an optional IOF RAM
//   page, and a freeze/NMI handshake with timeout.
// Ports:
//   clk32, reset                 clock, async active-high reset
//   cart_loading, cart_bank_*    CRT chip-packet table load interface
//   cart_attached, romL, romH,
//   IOE, IOF, mem_write,
//   c64_mem_address_in,
//   c64_data_out                 C64 bus decode and CPU access
//   freeze_key, nmi_ack          freeze button / NMI acknowledge
//   sdram_address_out            translated SDRAM byte address
//   exrom, game                  cartridge lines (active low)
//   iof_ce                       IOF access served by cartridge RAM
//   nmi, frozen                  freeze handshake status
//   bank_mask                    current mirroring mask
module cart_bank_mapper #(
  parameter int ADDR_W      = 25,
  parameter int DEPTH_LOG2  = 6,
  parameter int BANK_W      = 7,
  parameter int IOF_RAM     = 1,
  parameter int RAM_PAGE    = 'h8,
  parameter int NMI_TIMEOUT = 1024
) (
  input  logic              clk32,
  input  logic              reset,
  input  logic              cart_loading,
  input  logic              cart_bank_wr,
  input  logic [15:0]       cart_bank_num,
  input  logic [15:0]       cart_bank_laddr,
  input  logic [15:0]       cart_bank_size,
  input  logic [ADDR_W-1:0] cart_bank_raddr,
  input  logic              cart_attached,
  input  logic              romL,
  input  logic              romH,
  input  logic              IOE,
  input  logic              IOF,
  input  logic              mem_write,
  input  logic [15:0]       c64_mem_address_in,
  input  logic [7:0]        c64_data_out,
  input  logic              freeze_key,
  input  logic              nmi_ack,
  output logic [ADDR_W-1:0] sdram_address_out,
  output logic              exrom,
  output logic              game,
  output logic              iof_ce,
  output logic              nmi,
  output logic              frozen,
  output logic [BANK_W-1:0] bank_mask
);
  localparam int PW    = ADDR_W - 13;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = $clog2(NMI_TIMEOUT + 1);
  localparam logic [PW-1:0] PAGE_ONE = PW'(1);
  localparam logic [PW-1:0] RAM_PG   = PW'(RAM_PAGE);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_FROZEN} state_t;

  // ---------------- bank table (not reset: survives a CPU reset) ----------
  logic [PW-1:0]         r_lo [0:DEPTH-1];
  logic [PW-1:0]         r_hi [0:DEPTH-1];
  logic [DEPTH_LOG2-1:0] r_max_bank;
  logic                  r_loading_d;

  logic [PW-1:0]         w_page;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_tbl_wr;
  logic                  w_load_rise;

  assign w_page      = cart_bank_raddr[ADDR_W-1:13];
  assign w_idx       = cart_bank_num[DEPTH_LOG2-1:0];
  assign w_tbl_wr    = cart_bank_wr & (cart_bank_num < 16'(DEPTH));
  assign w_load_rise = cart_loading & ~r_loading_d;

  always_ff @(posedge clk32) begin
    r_loading_d <= cart_loading;
    if (w_tbl_wr) begin
      // Chips at $8000 carry ROML, and a 16K chip spills its upper half into ROMH.
      if (cart_bank_laddr <= 16'h8000) begin
        r_lo[w_idx] <= w_page;
        if (cart_bank_size > 16'h2000) r_hi[w_idx] <= w_page + PAGE_ONE;
      end else begin
        r_hi[w_idx] <= w_page;
      end
    end
    if (w_load_rise)
      r_max_bank <= w_tbl_wr ? w_idx : '0;
    else if (w_tbl_wr && (w_idx > r_max_bank))
      r_max_bank <= w_idx;
  end

  // Smear the top set bit downward: smallest 2^k-1 covering max_bank.
  logic [DEPTH_LOG2-1:0] w_smear;
  always_comb begin
    w_smear = r_max_bank;
    for (int i = 1; i < DEPTH_LOG2; i++) w_smear = w_smear | (w_smear >> i);
  end
  assign bank_mask = BANK_W'(w_smear);

  // ---------------- bus strobes and edge detectors ------------------------
  logic r_ioe_d, r_freeze_d, r_ack_d;
  logic r_disable, r_game_n, r_exrom_n;
  logic [BANK_W-1:0] r_bank_sel;
  logic [PW-1:0]     r_lo_page, r_hi_page;

  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      r_ioe_d    <= 1'b0;
      r_freeze_d <= 1'b0;
      r_ack_d    <= 1'b0;
    end else begin
      r_ioe_d    <= IOE;
      r_freeze_d <= freeze_key;
      r_ack_d    <= nmi_ack;
    end
  end

  logic w_ioe_wr, w_wr_bank, w_wr_ctrl, w_freeze_rise, w_ack_rise, w_freeze_act;
  assign w_ioe_wr      = IOE & ~r_ioe_d & mem_write & ~r_disable;
  assign w_wr_bank     = w_ioe_wr & ~c64_mem_address_in[1];
  assign w_wr_ctrl     = w_ioe_wr &  c64_mem_address_in[1];
  assign w_freeze_rise = freeze_key & ~r_freeze_d;
  assign w_ack_rise    = nmi_ack & ~r_ack_d;

  // ---------------- freeze FSM --------------------------------------------
  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_freeze_rise) w_state_nxt = S_REQ;
      // r_cnt==1 here means this cycle is the last of the NMI_TIMEOUT window.
      S_REQ:    if (w_ack_rise) w_state_nxt = S_FROZEN;
                else if (r_cnt == CNT_W'(1)) w_state_nxt = S_IDLE;
      S_FROZEN: if (w_wr_ctrl) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    nmi    = (r_state == S_REQ);
    frozen = (r_state == S_FROZEN);
  end

  assign w_freeze_act = (r_state == S_REQ) & w_ack_rise;

  always_ff @(posedge clk32 or posedge reset) begin
    if (reset)                                        r_cnt <= '0;
    else if (r_state == S_IDLE && w_state_nxt == S_REQ) r_cnt <= CNT_W'(NMI_TIMEOUT);
    else if (r_state == S_REQ)                        r_cnt <= r_cnt - CNT_W'(1);
  end

  // ---------------- mapping registers -------------------------------------
  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      r_bank_sel <= '0;
      r_game_n   <= 1'b0;
      r_exrom_n  <= 1'b0;
      r_disable  <= 1'b0;
      r_lo_page  <= '0;
      r_hi_page  <= '0;
    end else begin
      // Synchronous table read: pages trail bank_sel by one cycle.
      r_lo_page <= r_lo[r_bank_sel[DEPTH_LOG2-1:0]];
      r_hi_page <= r_hi[r_bank_sel[DEPTH_LOG2-1:0]];
      if (w_freeze_act) begin
        // Enter ULTIMAX on bank 0 so the freezer ROM answers the NMI; a
        // coincident register write is dropped.
        r_bank_sel <= '0;
        r_game_n   <= 1'b0;
        r_exrom_n  <= 1'b1;
        r_disable  <= 1'b0;
      end else begin
        if (w_wr_bank) r_bank_sel <= c64_data_out[BANK_W-1:0] & bank_mask;
        if (w_wr_ctrl) begin
          r_game_n  <= ~c64_data_out[0];
          r_exrom_n <= ~c64_data_out[1];
          r_disable <=  c64_data_out[7];
        end
      end
    end
  end

  assign exrom = ~cart_attached | r_exrom_n | r_disable;
  assign game  = ~cart_attached | r_game_n  | r_disable;

  // ---------------- address translation -----------------------------------
  always_comb begin
    sdram_address_out = ADDR_W'(c64_mem_address_in);
    iof_ce            = 1'b0;
    if (cart_attached) begin
      if (romL && !mem_write)
        sdram_address_out = {r_lo_page, c64_mem_address_in[12:0]};
      else if (romH && !mem_write)
        sdram_address_out = {r_hi_page, c64_mem_address_in[12:0]};
      else if (IOF && (IOF_RAM != 0)) begin
        sdram_address_out = {RAM_PG, 5'b0, c64_mem_address_in[7:0]};
        iof_ce            = 1'b1;
      end
    end
  end

  // Address low bits of a chip packet and high bank_sel/data bits are
  // intentionally unused.
  logic w_unused_bits;
  assign w_unused_bits = ^{cart_bank_raddr[12:0], r_bank_sel, c64_data_out};

endmodule

// File: tb/tb_cart_bank_mapper.sv
module tb_cart_bank_mapper;
  localparam int AW = 25;
  localparam int NT = 1024;
  localparam int RAM_PG = 'h8;

  logic          clk32 = 1'b0;
  logic          rst;
  logic          cart_loading, cart_bank_wr;
  logic [15:0]   cart_bank_num, cart_bank_laddr, cart_bank_size;
  logic [AW-1:0] cart_bank_raddr;
  logic          cart_attached, romL, romH, IOE, IOF, mem_write;
  logic [15:0]   c64_mem_address_in;
  logic [7:0]    c64_data_out;
  logic          freeze_key, nmi_ack;
  logic [AW-1:0] sdram_address_out;
  logic          exrom, game, iof_ce, nmi, frozen;
  logic [6:0]    bank_mask;

  cart_bank_mapper #(.ADDR_W(AW), .DEPTH_LOG2(6), .BANK_W(7), .IOF_RAM(1),
                     .RAM_PAGE(RAM_PG), .NMI_TIMEOUT(NT)) dut (
    .clk32(clk32), .reset(rst), .cart_loading(cart_loading), .cart_bank_wr(cart_bank_wr),
    .cart_bank_num(cart_bank_num), .cart_bank_laddr(cart_bank_laddr),
    .cart_bank_size(cart_bank_size), .cart_bank_raddr(cart_bank_raddr),
    .cart_attached(cart_attached), .romL(romL), .romH(romH), .IOE(IOE), .IOF(IOF),
    .mem_write(mem_write), .c64_mem_address_in(c64_mem_address_in),
    .c64_data_out(c64_data_out), .freeze_key(freeze_key), .nmi_ack(nmi_ack),
    .sdram_address_out(sdram_address_out), .exrom(exrom), .game(game), .iof_ce(iof_ce),
    .nmi(nmi), .frozen(frozen), .bank_mask(bank_mask));

  always #5 clk32 = ~clk32;

  // ---------------- behavioural model -------------------------------------
  int lo_m[64], hi_m[64];
  bit lo_v[64], hi_v[64];
  int max_m;   bit max_v;
  int sel_m, gn_m, en_m, dis_m;
  int lo_pg, hi_pg; bit lo_pv, hi_pv;
  int mode_m;      // 0 idle, 1 NMI requested, 2 frozen
  int remain_m;    // NMI-high cycles still to go before giving up
  bit p_ioe, p_fr, p_ack, p_ld;

  int n_checks = 0, n_err = 0;

  function automatic int mask_of(int m);
    int k = 0;
    while ((1 << k) - 1 < m) k++;
    return (1 << k) - 1;
  endfunction

  task automatic model_reset();
    sel_m = 0; gn_m = 0; en_m = 0; dis_m = 0;
    lo_pg = 0; hi_pg = 0; lo_pv = 1; hi_pv = 1;
    mode_m = 0; remain_m = 0; p_ioe = 0; p_fr = 0; p_ack = 0;
  endtask

  task automatic table_step();
    int pg, n;
    if (cart_loading && !p_ld) begin max_m = 0; max_v = 1; end
    if (cart_bank_wr && cart_bank_num < 64) begin
      n  = int'(cart_bank_num);
      pg = int'(cart_bank_raddr / 'h2000) % 'h1000;
      if (cart_bank_laddr <= 'h8000) begin
        lo_m[n] = pg; lo_v[n] = 1;
        if (cart_bank_size > 'h2000) begin hi_m[n] = (pg + 1) % 'h1000; hi_v[n] = 1; end
      end else begin
        hi_m[n] = pg; hi_v[n] = 1;
      end
      if (n > max_m) max_m = n;
    end
    p_ld = cart_loading;
  endtask

  task automatic ctrl_step(int msk);
    bit ioe_r, fr_r, ak_r, wr;
    ioe_r = IOE && !p_ioe;
    fr_r  = freeze_key && !p_fr;
    ak_r  = nmi_ack && !p_ack;
    wr    = ioe_r && mem_write && (dis_m == 0);
    if (mode_m == 1 && ak_r) begin
      mode_m = 2; dis_m = 0; gn_m = 0; en_m = 1; sel_m = 0;
    end else begin
      if (mode_m == 0 && fr_r) begin mode_m = 1; remain_m = NT; end
      else if (mode_m == 1) begin
        remain_m--;
        if (remain_m == 0) mode_m = 0;
      end
      if (wr) begin
        if (c64_mem_address_in[1] == 1'b0) sel_m = (int'(c64_data_out) % 128) & msk;
        else begin
          gn_m  = c64_data_out[0] ? 0 : 1;
          en_m  = c64_data_out[1] ? 0 : 1;
          dis_m = c64_data_out[7] ? 1 : 0;
          if (mode_m == 2) mode_m = 0;
        end
      end
    end
    p_ioe = IOE; p_fr = freeze_key; p_ack = nmi_ack;
  endtask

  initial begin
    int msk, nlo, nhi; bit nlv, nhv;
    foreach (lo_v[i]) begin lo_v[i] = 0; hi_v[i] = 0; end
    max_m = 0; max_v = 0; p_ld = 0;
    model_reset();
    forever begin
      @(posedge clk32);
      msk = mask_of(max_m);
      nlo = lo_m[sel_m]; nlv = lo_v[sel_m];
      nhi = hi_m[sel_m]; nhv = hi_v[sel_m];
      table_step();
      if (rst) model_reset();
      else begin
        lo_pg = nlo; lo_pv = nlv; hi_pg = nhi; hi_pv = nhv;
        ctrl_step(msk);
      end
    end
  end

  // ---------------- checking ----------------------------------------------
  task automatic check(string nm, longint got, longint exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", nm, got, exp, $time);
    end
  endtask

  task automatic compare_model();
    int e_gn, e_en, e_dis, e_mode, a;
    longint e_lo, e_hi, ea;
    bit lv, hv, need, rl, rh;
    if (rst) begin
      e_gn = 0; e_en = 0; e_dis = 0; e_mode = 0; e_lo = 0; e_hi = 0; lv = 1; hv = 1;
    end else begin
      e_gn = gn_m; e_en = en_m; e_dis = dis_m; e_mode = mode_m;
      e_lo = lo_pg; e_hi = hi_pg; lv = lo_pv; hv = hi_pv;
    end
    a    = int'(c64_mem_address_in);
    rl   = romL && !mem_write;
    rh   = romH && !mem_write;
    need = 1;
    if (!cart_attached)  ea = a;
    else if (rl) begin   ea = e_lo * 'h2000 + a % 'h2000; need = lv; end
    else if (rh) begin   ea = e_hi * 'h2000 + a % 'h2000; need = hv; end
    else if (IOF)        ea = RAM_PG * 'h2000 + a % 'h100;
    else                 ea = a;
    if (need) check("addr", sdram_address_out, ea);
    check("exrom", exrom, (!cart_attached || e_en != 0 || e_dis != 0));
    check("game", game, (!cart_attached || e_gn != 0 || e_dis != 0));
    check("iof_ce", iof_ce, (cart_attached && IOF && !rl && !rh));
    check("nmi", nmi, (e_mode == 1));
    check("frozen", frozen, (e_mode == 2));
    if (max_v) check("bank_mask", bank_mask, mask_of(max_m));
  endtask

  // One cycle: compare at the falling edge, return just after the next rise.
  task automatic step();
    @(negedge clk32);
    compare_model();
    @(posedge clk32);
    #1;
  endtask

  task automatic bus(bit l, bit h, bit e, bit f, bit w, logic [15:0] a, logic [7:0] d);
    romL = l; romH = h; IOE = e; IOF = f; mem_write = w;
    c64_mem_address_in = a; c64_data_out = d;
  endtask

  task automatic ioe_write(logic [15:0] a, logic [7:0] d);
    bus(0, 0, 1, 0, 1, a, d); step();
    bus(0, 0, 0, 0, 0, a, d); step();
  endtask

  task automatic chip(int num, int laddr, int size, int raddr);
    cart_bank_wr = 1; cart_bank_num = 16'(num); cart_bank_laddr = 16'(laddr);
    cart_bank_size = 16'(size); cart_bank_raddr = AW'(raddr);
    step();
    cart_bank_wr = 0;
  endtask

  // ---------------- stimulus ----------------------------------------------
  initial begin
    int cnt;
    rst = 1; cart_loading = 0; cart_bank_wr = 0; cart_bank_num = 0;
    cart_bank_laddr = 0; cart_bank_size = 0; cart_bank_raddr = '0;
    cart_attached = 1; freeze_key = 0; nmi_ack = 0;
    bus(0, 0, 0, 0, 0, 16'h0, 8'h0);
    @(posedge clk32); #1;
    step();
    // Reset state: page 0, 16K config, no NMI.
    bus(1, 0, 0, 0, 0, 16'h8123, 8'h0); #2;
    check("rst_addr", sdram_address_out, 'h0123);
    check("rst_exrom", exrom, 0);
    check("rst_game", game, 0);
    check("rst_nmi", nmi, 0);
    check("rst_frozen", frozen, 0);
    step();
    rst = 0;
    bus(0, 0, 0, 0, 0, 16'h0, 8'h0);
    step();

    // Fill every table entry: ROML at 'h200+n, ROMH at 'h300+n.
    cart_loading = 1;
    for (int n = 0; n < 64; n++) begin
      chip(n, 'h8000, 'h2000, 'h400000 + n * 'h2000);
      chip(n, 'hA000, 'h2000, 'h600000 + n * 'h2000);
    end
    cart_loading = 0; step(); #2;
    check("mask_full", bank_mask, 'h3F);

    // Second load of 16K chips 0..4.
    cart_loading = 1; step();
    for (int n = 0; n < 5; n++) chip(n, 'h8000, 'h4000, 'h100000 + n * 'h4000);
    cart_loading = 0; step(); #2;
    check("mask_5banks", bank_mask, 7);

    ioe_write(16'hDE00, 8'h02);
    bus(1, 0, 0, 0, 0, 16'h8123, 8'h0); #2;
    check("lo2", sdram_address_out, 'h108123);
    bus(0, 1, 0, 0, 0, 16'hA123, 8'h0); #2;
    check("hi2", sdram_address_out, 'h10A123);
    step();

    ioe_write(16'hDE00, 8'h0D);  // masked to bank 5, from the first load
    bus(1, 0, 0, 0, 0, 16'h8123, 8'h0); #2;
    check("lo5", sdram_address_out, 'h40A123);
    step();

    ioe_write(16'hDE02, 8'h05); #2;
    check("cfg05_game", game, 0);
    check("cfg05_exrom", exrom, 1);
    bus(0, 0, 0, 1, 0, 16'hDF10, 8'h0); #2;
    check("iof_addr", sdram_address_out, 'h10010);
    check("iof_ce", iof_ce, 1);
    step();

    ioe_write(16'hDE02, 8'h80); #2;
    check("dis_exrom", exrom, 1);
    check("dis_game", game, 1);
    ioe_write(16'hDE00, 8'h02);
    bus(1, 0, 0, 0, 0, 16'h8123, 8'h0); #2;
    check("dis_sel", sdram_address_out, 'h40A123);
    step();

    // Freeze with ack after 10 NMI cycles.
    bus(0, 0, 0, 0, 0, 16'h0, 8'h0);
    freeze_key = 1; step();
    cnt = 0;
    repeat (9) begin #2; if (nmi) cnt++; step(); end
    nmi_ack = 1; #2; if (nmi) cnt++; step();
    #2;
    check("frz_nmi_len", cnt, 10);
    check("frz_nmi", nmi, 0);
    check("frz_frozen", frozen, 1);
    check("frz_game", game, 0);
    check("frz_exrom", exrom, 1);
    step();
    nmi_ack = 0;
    bus(1, 0, 0, 0, 0, 16'h8123, 8'h0); #2;
    check("frz_bank0", sdram_address_out, 'h100123);
    step();
    ioe_write(16'hDE02, 8'h03); #2;
    check("unfrz_frozen", frozen, 0);
    check("unfrz_game", game, 0);
    check("unfrz_exrom", exrom, 0);

    // Freeze with no ack: NMI must last exactly NT cycles.
    freeze_key = 0; step();
    freeze_key = 1; step();
    cnt = 0; #2;
    while (nmi && cnt < 2 * NT) begin cnt++; step(); #2; end
    check("timeout_len", cnt, NT);
    check("timeout_frozen", frozen, 0);
    step();

    // Reset in the middle of a request.
    freeze_key = 0; step();
    freeze_key = 1; step(); step(); #2;
    check("req_nmi", nmi, 1);
    rst = 1; #1;
    check("async_nmi", nmi, 0);
    step(); step();
    rst = 0; step(); #2;
    check("mask_kept", bank_mask, 7);
    chip(70, 'h8000, 'h2000, 0); step(); #2;
    check("bank70_noload", bank_mask, 7);
    cart_loading = 1;
    chip(70, 'h8000, 'h2000, 0);
    chip(1, 'h8000, 'h2000, 'h20000);
    cart_loading = 0; step(); #2;
    check("bank70_load", bank_mask, 1);
    step();

    // Randomised traffic checked against the model every cycle.
    freeze_key = 0;
    for (int i = 0; i < 4000; i++) begin
      int r;
      logic [7:0] d;
      rst = ($urandom % 800 == 0);
      cart_attached = ($urandom % 10 != 0);
      if ($urandom % 300 == 0) cart_loading = ~cart_loading;
      if ($urandom % 150 == 0) freeze_key = ~freeze_key;
      if ($urandom % 8 == 0) nmi_ack = ~nmi_ack;
      cart_bank_wr = ($urandom % 20 == 0);
      cart_bank_num   = 16'($urandom_range(0, 79));
      r = $urandom % 4;
      cart_bank_laddr = (r == 0) ? 16'h8000 : (r == 1) ? 16'hA000 : (r == 2) ? 16'h6000 : 16'hE000;
      cart_bank_size  = ($urandom % 2) ? 16'h2000 : 16'h4000;
      cart_bank_raddr = AW'($urandom);
      d = 8'($urandom);
      if ($urandom % 30 != 0) d[7] = 1'b0;
      r = $urandom % 6;
      bus(r == 0, r == 1, r == 2, r == 3, 1'($urandom % 2), 16'($urandom), d);
      step();
    end
    rst = 0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end
endmodule
